// File: rtl/up_bus_responder.sv
// up_bus_responder: FPGA-side responder for the uP byte-handshake bus.
// Each transaction receives a 6-byte command packet (cmd, addr, data LS byte
// first). It then issues one register write or read and returns an 8-byte
// reply: 32-bit data, then 32-bit status, LS byte first.
//
// Ports:
//   clk, reset              system clock, async active-low reset
//   async_uP_start          transaction start (asynchronous, synchronised here)
//   async_uP_handshake_1    uP strobe/ack (asynchronous)
//   async_uP_RW             1 = uP drives bus, 0 = FPGA drives (asynchronous)
//   uP_data_in/out/oe       pad data in, data out, output enable
//   uP_handshake_2          FPGA strobe/ack
//   uP_ack                  transaction complete, held until next start edge
//   reg_*                   internal register port (1-cycle wr/rd strobes)
//   timeout_err             1-cycle pulse when a wait state is aborted
module up_bus_responder #(
  parameter int CMD_BYTES      = 6,
  parameter int RESP_BYTES     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        async_uP_start,
  input  logic        async_uP_handshake_1,
  input  logic        async_uP_RW,
  input  logic [7:0]  uP_data_in,
  output logic [7:0]  uP_data_out,
  output logic        uP_data_oe,
  output logic        uP_handshake_2,
  output logic        uP_ack,
  output logic [7:0]  reg_address,
  output logic [31:0] reg_wr_data,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [31:0] reg_rd_data,
  output logic        timeout_err
);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW  = $clog2((CMD_BYTES > RESP_BYTES ? CMD_BYTES : RESP_BYTES) + 1);
  localparam int PIW = $clog2(CMD_BYTES);
  localparam int RIW = $clog2(RESP_BYTES);

  typedef enum logic [3:0] {
    IDLE, RX_WAIT_H1_HI, RX_WAIT_H1_LO, EXEC, EXEC_RD,
    TX_SETUP, TX_WAIT_H1_HI, TX_WAIT_H1_LO, DONE
  } state_t;

  // 2-flop synchronisers; bit 1 is the synchronised value
  logic [1:0] start_sync_q, h1_sync_q, rw_sync_q;
  logic       start_prev_q;
  logic       start_s, h1_s, rw_s, start_rise;

  assign start_s    = start_sync_q[1];
  assign h1_s       = h1_sync_q[1];
  assign rw_s       = rw_sync_q[1];
  assign start_rise = start_s & ~start_prev_q;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 tmo_q, tmo_d;
  logic [BW-1:0]                 cnt_q, cnt_d;
  logic [CMD_BYTES-1:0][7:0]     packet_q, packet_d;
  logic [RESP_BYTES-1:0][7:0]    reply_q, reply_d;
  logic [7:0]  dout_q, dout_d, addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic oe_q, oe_d, h2_q, h2_d, ack_q, ack_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic tmo_err_q, tmo_err_d, setup_q, setup_d, wait_st;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    packet_d  = packet_q;
    reply_d   = reply_q;
    dout_d    = dout_q;
    oe_d      = oe_q;
    h2_d      = h2_q;
    ack_d     = ack_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    setup_d   = setup_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tmo_err_d = 1'b0;
    wait_st   = 1'b0;
    case (state_q)
      IDLE: if (start_rise) begin
        ack_d   = 1'b0;
        cnt_d   = '0;
        state_d = RX_WAIT_H1_HI;
      end
      RX_WAIT_H1_HI: begin
        wait_st = 1'b1;
        if (h1_s && rw_s) begin
          // data pad is sampled raw: the uP set it up before raising h1
          packet_d[cnt_q[PIW-1:0]] = uP_data_in;
          h2_d    = 1'b1;
          state_d = RX_WAIT_H1_LO;
        end
      end
      RX_WAIT_H1_LO: begin
        wait_st = 1'b1;
        if (!h1_s) begin
          h2_d    = 1'b0;
          cnt_d   = cnt_q + BW'(1);
          state_d = (cnt_q == BW'(CMD_BYTES - 1)) ? EXEC : RX_WAIT_H1_HI;
        end
      end
      EXEC: begin
        cnt_d  = '0;
        addr_d = packet_q[1];
        case (packet_q[0])
          8'd1: begin
            wr_en_d = 1'b1;
            wdata_d = {packet_q[5], packet_q[4], packet_q[3], packet_q[2]};
            reply_d = {16'h0, 8'h01, 8'h00, packet_q[5], packet_q[4], packet_q[3], packet_q[2]};
            state_d = TX_SETUP;
          end
          8'd0: begin
            rd_en_d = 1'b1;
            state_d = EXEC_RD;
          end
          default: begin
            reply_d = {16'h0, packet_q[0], 8'h01, 32'h0};
            state_d = TX_SETUP;
          end
        endcase
      end
      // strobe is out during the first EXEC_RD cycle; data is valid in the second
      EXEC_RD: if (tmo_q == CW'(1)) begin
        reply_d = {32'h0, reg_rd_data};
        state_d = TX_SETUP;
      end
      TX_SETUP: begin
        wait_st = 1'b1;
        if (!rw_s) begin
          if (!setup_q) begin
            oe_d    = 1'b1;
            dout_d  = reply_q[cnt_q[RIW-1:0]];
            setup_d = 1'b1;
          end else begin
            // one cycle of data setup before the strobe
            h2_d    = 1'b1;
            setup_d = 1'b0;
            state_d = TX_WAIT_H1_HI;
          end
        end
      end
      TX_WAIT_H1_HI: begin
        wait_st = 1'b1;
        if (h1_s) begin
          h2_d    = 1'b0;
          state_d = TX_WAIT_H1_LO;
        end
      end
      TX_WAIT_H1_LO: begin
        wait_st = 1'b1;
        if (!h1_s) begin
          cnt_d   = cnt_q + BW'(1);
          state_d = (cnt_q == BW'(RESP_BYTES - 1)) ? DONE : TX_SETUP;
        end
      end
      DONE: begin
        oe_d    = 1'b0;
        dout_d  = 8'h00;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // abort overrides whatever the wait state decided this cycle
    if (wait_st && tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = IDLE;
      h2_d      = 1'b0;
      oe_d      = 1'b0;
      ack_d     = 1'b0;
      setup_d   = 1'b0;
      tmo_err_d = 1'b1;
    end

    // per-state dwell counter, saturating so IDLE never wraps it
    if (state_d != state_q)                  tmo_d = '0;
    else if (tmo_q != CW'(TIMEOUT_CYCLES - 1)) tmo_d = tmo_q + CW'(1);
    else                                     tmo_d = tmo_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_sync_q <= '0;
      h1_sync_q    <= '0;
      rw_sync_q    <= '0;
      start_prev_q <= 1'b0;
      state_q      <= IDLE;
      tmo_q        <= '0;
      cnt_q        <= '0;
      packet_q     <= '0;
      reply_q      <= '0;
      dout_q       <= '0;
      oe_q         <= 1'b0;
      h2_q         <= 1'b0;
      ack_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      tmo_err_q    <= 1'b0;
      setup_q      <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[0], async_uP_start};
      h1_sync_q    <= {h1_sync_q[0], async_uP_handshake_1};
      rw_sync_q    <= {rw_sync_q[0], async_uP_RW};
      start_prev_q <= start_s;
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
      packet_q     <= packet_d;
      reply_q      <= reply_d;
      dout_q       <= dout_d;
      oe_q         <= oe_d;
      h2_q         <= h2_d;
      ack_q        <= ack_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      tmo_err_q    <= tmo_err_d;
      setup_q      <= setup_d;
    end
  end

  // the pad is never driven while the uP claims the bus
  assign uP_data_oe     = oe_q & ~rw_s;
  assign uP_data_out    = dout_q;
  assign uP_handshake_2 = h2_q;
  assign uP_ack         = ack_q;
  assign reg_address    = addr_q;
  assign reg_wr_data    = wdata_q;
  assign reg_wr_en      = wr_en_q;
  assign reg_rd_en      = rd_en_q;
  assign timeout_err    = tmo_err_q;
endmodule

// File: tb/tb_up_bus_responder.sv
module tb_up_bus_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        async_uP_start, async_uP_handshake_1, async_uP_RW;
  logic [7:0]  uP_data_in, uP_data_out, reg_address;
  logic        uP_data_oe, uP_handshake_2, uP_ack, reg_wr_en, reg_rd_en, timeout_err;
  logic [31:0] reg_wr_data, reg_rd_data;

  always #5 clk = ~clk;

  up_bus_responder #(.CMD_BYTES(6), .RESP_BYTES(8), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .async_uP_start(async_uP_start), .async_uP_handshake_1(async_uP_handshake_1),
    .async_uP_RW(async_uP_RW), .uP_data_in(uP_data_in), .uP_data_out(uP_data_out),
    .uP_data_oe(uP_data_oe), .uP_handshake_2(uP_handshake_2), .uP_ack(uP_ack),
    .reg_address(reg_address), .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .timeout_err(timeout_err));

  // register file seen by the DUT: read data valid one cycle after the strobe
  logic [31:0] rf [256] = '{default: 32'h0};
  always @(posedge clk) begin
    if (reg_wr_en) rf[reg_address] <= reg_wr_data;
    if (reg_rd_en) reg_rd_data <= rf[reg_address];
  end

  // bench copy of the RW synchroniser for the bus-direction check
  logic rw_s1, rw_s2;
  always @(posedge clk or negedge reset)
    if (!reset) {rw_s2, rw_s1} <= 2'b00;
    else        {rw_s2, rw_s1} <= {rw_s1, async_uP_RW};

  // scoreboard queues
  logic [7:0]  exp_bytes[$];
  logic [39:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  bit          exp_tmo[$];
  typedef struct { string name; logic [63:0] act, lo, hi; } chk_t;
  chk_t chk_q[$];

  // behavioural register contents
  logic [31:0] mdl [256] = '{default: 32'h0};

  int vectors = 0, errors = 0;

  // monitor: sole place where comparisons are made and counted
  logic h2_prev = 1'b0;
  logic [7:0] eb, ea;
  logic [39:0] ew;
  chk_t c;
  always @(negedge clk) begin
    h2_prev <= uP_handshake_2;
    if (uP_data_oe) begin
      vectors++;
      if (rw_s2) begin errors++; $display("FAIL bus_dir: oe=1 while RW=%0d, want RW=0", rw_s2); end
    end
    if (uP_handshake_2 && !h2_prev && uP_data_oe) begin
      vectors++;
      if (exp_bytes.size() == 0) begin
        errors++; $display("FAIL reply_byte: got %02h, want none", uP_data_out);
      end else begin
        eb = exp_bytes.pop_front();
        if (uP_data_out !== eb) begin errors++; $display("FAIL reply_byte: got %02h, want %02h", uP_data_out, eb); end
      end
    end
    if (reg_wr_en) begin
      vectors++;
      if (exp_wr.size() == 0) begin
        errors++; $display("FAIL wr_strobe: got addr %02h data %08h, want no write", reg_address, reg_wr_data);
      end else begin
        ew = exp_wr.pop_front();
        if ({reg_address, reg_wr_data} !== ew) begin
          errors++; $display("FAIL wr_strobe: got %010h, want %010h", {reg_address, reg_wr_data}, ew);
        end
      end
    end
    if (reg_rd_en) begin
      vectors++;
      if (exp_rd.size() == 0) begin
        errors++; $display("FAIL rd_strobe: got addr %02h, want no read", reg_address);
      end else begin
        ea = exp_rd.pop_front();
        if (reg_address !== ea) begin errors++; $display("FAIL rd_strobe: got addr %02h, want %02h", reg_address, ea); end
      end
    end
    if (timeout_err) begin
      vectors++;
      if (exp_tmo.size() == 0) begin errors++; $display("FAIL timeout_err: got pulse, want none"); end
      else void'(exp_tmo.pop_front());
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      vectors++;
      if (c.act < c.lo || c.act > c.hi) begin
        errors++;
        $display("FAIL %s: got %0h, want %0h..%0h", c.name, c.act, c.lo, c.hi);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] lo, input logic [63:0] hi);
    chk_t r;
    r.name = nm; r.act = act; r.lo = lo; r.hi = hi;
    chk_q.push_back(r);
  endtask

  // bounded wait on one DUT output: 0=h2, 1=ack, 2=timeout_err
  task automatic wait_sig(input int which, input logic val, input string nm, output int n);
    logic s;
    n = 0;
    forever begin
      s = (which == 0) ? uP_handshake_2 : (which == 1) ? uP_ack : timeout_err;
      if (s === val || n >= 2000) break;
      @(negedge clk); n++;
    end
    if (n >= 2000) chk({"wait_", nm}, 64'(n), 64'(0), 64'(1999));
  endtask

  task automatic start_pulse();
    int n;
    async_uP_start = 1'b1;
    wait_sig(1, 1'b0, "ack_drop", n);
    chk("ack_drop_lat", 64'(n), 64'(0), 64'(6));
    repeat (2) @(negedge clk);
    async_uP_start = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    int n;
    async_uP_RW = 1'b1; uP_data_in = b; async_uP_handshake_1 = 1'b1;
    wait_sig(0, 1'b1, "rx_h2_hi", n);
    async_uP_handshake_1 = 1'b0;
    wait_sig(0, 1'b0, "rx_h2_lo", n);
  endtask

  // one full transaction; rst_at >= 0 pulses reset while reply byte rst_at is presented
  task automatic txn(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] wd, input int rst_at);
    logic [31:0] rdat, st;
    logic [63:0] rep;
    logic [7:0]  pkt [6];
    int n;
    pkt = '{cmd, addr, wd[7:0], wd[15:8], wd[23:16], wd[31:24]};
    if (cmd == 8'd1) begin
      mdl[addr] = wd; rdat = wd; st = 32'h0000_0100; exp_wr.push_back({addr, wd});
    end else if (cmd == 8'd0) begin
      rdat = mdl[addr]; st = 32'h0; exp_rd.push_back(addr);
    end else begin
      rdat = 32'h0; st = {16'h0, cmd, 8'h01};
    end
    rep = {st, rdat};
    for (int i = 0; i < 8; i++) exp_bytes.push_back(rep[8*i +: 8]);
    start_pulse();
    for (int i = 0; i < 6; i++) rx_byte(pkt[i]);
    async_uP_RW = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_sig(0, 1'b1, "tx_h2_hi", n);
      if (i == rst_at) begin
        #2 reset = 1'b0;
        #1 chk("rst_oe_h2_ack", {61'h0, uP_data_oe, uP_handshake_2, uP_ack}, 64'h0, 64'h0);
        @(negedge clk);
        async_uP_RW = 1'b1;
        exp_bytes.delete();
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        return;
      end
      async_uP_handshake_1 = 1'b1;
      wait_sig(0, 1'b0, "tx_h2_lo", n);
      async_uP_handshake_1 = 1'b0;
    end
    wait_sig(1, 1'b1, "ack_hi", n);
    chk("ack_done", 64'(uP_ack), 64'h1, 64'h1);
    async_uP_RW = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, r;
    logic [7:0] cmd, addr;
    reset = 1'b0; async_uP_start = 1'b0; async_uP_handshake_1 = 1'b0;
    async_uP_RW = 1'b1; uP_data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outs", {10'h0, uP_data_out, uP_data_oe, uP_handshake_2, uP_ack, reg_address,
                       reg_wr_en, reg_rd_en, timeout_err, reg_wr_data}, 64'h0, 64'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    txn(8'h01, 8'h10, 32'h1234_5678, -1);
    chk("rf_10_write", 64'(rf[8'h10]), 64'h1234_5678, 64'h1234_5678);
    txn(8'h01, 8'h10, 32'd100, -1);
    txn(8'h00, 8'h10, 32'h0, -1);
    txn(8'h07, 8'h22, 32'hDEAD_BEEF, -1);

    // stall after byte 3 of a write: abort, no strobe
    exp_tmo.push_back(1'b1);
    start_pulse();
    rx_byte(8'h01); rx_byte(8'h44); rx_byte(8'hAA);
    wait_sig(2, 1'b1, "timeout", n);
    chk("tmo_latency", 64'(n), 64'd98, 64'd102);
    @(negedge clk);
    chk("tmo_outs", {61'h0, uP_data_oe, uP_handshake_2, uP_ack}, 64'h0, 64'h0);
    txn(8'h01, 8'h44, 32'h0BAD_F00D, -1);

    // reset during reply byte 5, then a clean transaction
    txn(8'h01, 8'h33, 32'hCAFE_F00D, 5);
    txn(8'h00, 8'h33, 32'h0, -1);

    // back-to-back: ack held in between, dropped by the next start edge
    txn(8'h01, 8'h55, 32'h0102_0304, -1);
    repeat (10) @(negedge clk);
    chk("ack_hold", 64'(uP_ack), 64'h1, 64'h1);
    txn(8'h00, 8'h55, 32'h0, -1);

    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 9));
      addr = 8'h10 + 8'($urandom_range(0, 5));
      if (r < 4)      cmd = 8'h00;
      else if (r < 8) cmd = 8'h01;
      else            cmd = 8'h02 + 8'($urandom_range(0, 253));
      txn(cmd, addr, $urandom, -1);
    end

    repeat (4) @(negedge clk);
    chk("left_bytes", 64'(exp_bytes.size()), 64'h0, 64'h0);
    chk("left_wr",    64'(exp_wr.size()),    64'h0, 64'h0);
    chk("left_rd",    64'(exp_rd.size()),    64'h0, 64'h0);
    chk("left_tmo",   64'(exp_tmo.size()),   64'h0, 64'h0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
